compare_sort_engine: RTL

//  Sorts a block of N unsigned 8-bit words in ascending order by bubble sort. Uses the

---
 rtl/compare_sort_engine.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/compare_sort_engine.sv
// Block bubble sorter: loads N words, sorts them ascending with an external comparator, streams them out.
// Optional SORT_STATS_EN adds a saturating per-block swap counter on the swap_cnt port.
module compare_sort_engine #(
  parameter int unsigned N      = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  input  logic              cmp_eq,
  input  logic              cmp_gt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
`ifdef SORT_STATS_EN
  ,
  output logic [15:0]       swap_cnt
`endif
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N - 2);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SORT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [DATA_W-1:0] mem [N];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  j_q;
  logic [IDX_W-1:0]  p_q;
  logic              swapped_q;

  logic              load_fire;
  logic              load_last;
  logic              out_fire;
  logic              out_last;
  logic              do_swap;
  logic              pass_end;
  logic              sort_done;
  logic [IDX_W-1:0]  pass_last;
  logic [IDX_W-1:0]  j_nxt;
  logic [DATA_W-1:0] sort_head;

  // Handshake and sort-pass control decode
  always_comb begin
    load_fire = 1'b0;
    load_last = 1'b0;
    out_fire  = 1'b0;
    out_last  = 1'b0;
    do_swap   = 1'b0;
    pass_end  = 1'b0;
    sort_done = 1'b0;
    pass_last = LAST_PASS - p_q;
    j_nxt     = j_q + IDX_ONE;
    if (state_q == S_LOAD) begin
      load_fire = in_valid & in_ready;
      load_last = load_fire & (wr_idx == LAST_IDX);
    end
    if (state_q == S_OUT) begin
      out_fire = out_valid & out_ready;
      out_last = out_fire & (rd_idx == LAST_IDX);
    end
    if (state_q == S_SORT) begin
      // Equal operands never swap, which keeps the sort stable.
      do_swap   = cmp_gt & ~cmp_eq;
      pass_end  = (j_q == pass_last);
      sort_done = pass_end & ((p_q == LAST_PASS) | ~(swapped_q | do_swap));
    end
    // The last compare of a pass may swap slot 0, so OUT's first word follows the swap.
    sort_head = (do_swap && (j_q == '0)) ? mem[1] : mem[0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (load_last) state_d = S_SORT;
      S_SORT:  if (sort_done) state_d = S_OUT;
      S_OUT:   if (out_last)  state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Comparator operands, live only while sorting
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    if (state_q == S_SORT) begin
      cmp_a = mem[j_q];
      cmp_b = mem[j_nxt];
    end
  end

  // Registered status and output data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      in_ready  <= (state_d == S_LOAD);
      busy      <= (state_d != S_LOAD);
      out_valid <= (state_d == S_OUT);
      if ((state_q == S_SORT) && (state_d == S_OUT)) begin
        out_data <= sort_head;
      end else if (out_fire && !out_last) begin
        out_data <= mem[rd_idx + IDX_ONE];
      end
    end
  end

  // Load, pass and read indices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      j_q       <= '0;
      p_q       <= '0;
      swapped_q <= 1'b0;
    end else begin
      if (load_fire) begin
        wr_idx <= load_last ? '0 : wr_idx + IDX_ONE;
      end
      if (load_last) begin
        j_q       <= '0;
        p_q       <= '0;
        swapped_q <= 1'b0;
      end else if (state_q == S_SORT) begin
        if (sort_done) begin
          j_q       <= '0;
          p_q       <= '0;
          swapped_q <= 1'b0;
        end else if (pass_end) begin
          j_q       <= '0;
          p_q       <= p_q + IDX_ONE;
          swapped_q <= 1'b0;
        end else begin
          j_q       <= j_nxt;
          swapped_q <= swapped_q | do_swap;
        end
      end
      if (out_fire) begin
        rd_idx <= out_last ? '0 : rd_idx + IDX_ONE;
      end
    end
  end

  // Word storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[wr_idx] <= in_data;
    end else if (do_swap) begin
      mem[j_q]   <= mem[j_nxt];
      mem[j_nxt] <= mem[j_q];
    end
  end

`ifdef SORT_STATS_EN
  // Per-block swap count, cleared as each sort begins, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_cnt <= '0;
    end else if (load_last) begin
      swap_cnt <= '0;
    end else if (do_swap && (swap_cnt != 16'hFFFF)) begin
      swap_cnt <= swap_cnt + 16'd1;
    end
  end
`endif

endmodule
